muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative unsigned multiply/divide unit for the little-computer datapath.
- Consumes rs_val/rt_val read from the register file.
- Produces a single-cycle write-back request (rd, data, enable) that drives the register file's rd/reg_in/reg_write_en inputs.
- Multi-cycle: one operand bit per clock; the control unit stalls on busy.

Parameters:
- WIDTH, 16, operand/result width (matches `REG_WIDTH).
- RADDR_W, 3, register index width (matches `NUM_REGS_WIDTH).

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder)
- flush  input  1  synchronous abort; discards the current operation
- rs_val  input  WIDTH  multiplicand / dividend
- rt_val  input  WIDTH  multiplier / divisor
- rd_in  input  RADDR_W  destination register index
- busy  output  1  high from the edge after start through the DONE cycle
- done  output  1  one-cycle completion pulse
- wb_en  output  1  one-cycle register write enable (same cycle as done)
- wb_rd  output  RADDR_W  destination index, valid while wb_en is high
- wb_data  output  WIDTH  result; holds its value until the next completion
- div_by_zero  output  1  sticky per operation: set with done on divisor 0, cleared on next accepted start

Behaviour:
- Reset, asynchronous while RST is high:
  - state=IDLE; busy, done, wb_en, div_by_zero = 0.
  - wb_rd = 0, wb_data = 0; internal counter and accumulators = 0.
- State IDLE:
  - If start=1 at an edge: latch op, rs_val, rt_val, rd_in; clear div_by_zero; busy=1.
  - Next state is RUN, or DONE directly if op is DIV/REM and rt_val=0.
- State RUN:
  - Counter counts from 0 to WIDTH-1, one step per edge.
  - MUL/MULH: shift-add into a 2*WIDTH-bit product.
  - DIV/REM: restoring division, one quotient bit per step, with a WIDTH+1-bit partial remainder.
  - After the step with counter=WIDTH-1, go to DONE.
- State DONE, exactly one cycle:
  - done=1, wb_en=1, wb_rd = latched rd.
  - wb_data by op:
    - MUL: product[WIDTH-1:0]
    - MULH: product[2W-1:W]
    - DIV: quotient
    - REM: remainder
  - Next edge returns to IDLE; busy=0, done=0, wb_en=0.
- Latency:
  - Accept edge E0, then RUN edges E1..E_WIDTH.
  - wb_en is high in the cycle after E_WIDTH (17 cycles after accept at WIDTH=16).
  - Back-to-back: start can be accepted at the edge leaving DONE? No. start is sampled only in IDLE, so the next accept is one cycle after DONE.
- Divide by zero:
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - DONE occurs in the cycle after E0; write-back still happens.
- Simultaneous events:
  - start while busy: ignored, not queued.
  - flush during RUN or DONE: return to IDLE at that edge. If asserted during DONE, wb_en is suppressed combinationally in that cycle. No write-back; wb_data is unchanged.
  - flush and start together in IDLE: flush wins, nothing is accepted.
- Reset mid-operation: all outputs drop immediately, with no write-back.
- Arithmetic: unsigned, modulo 2^WIDTH for each half; no overflow flag.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - Operands are two's complement; magnitudes are computed at accept and the result is sign-corrected in DONE.
  - MULH returns the signed high half.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / -1 gives quotient=MIN, remainder=0.
  - Divide by zero gives quotient = -1 (all ones), remainder = dividend.
  - Latency is unchanged.
- Undefined: all operations are unsigned as specified above; no sign logic is instantiated.

Test Plan:
- Reset: RST=1 mid-RUN -> busy=0, wb_en=0, wb_data=0 immediately; no wb_en pulse within the following 20 cycles.
- MUL 7*6, rd_in=3 -> wb_en=1 exactly 17 cycles after the accept edge, with wb_rd=3, wb_data=42; busy=0 the cycle after.
- 0xFFFF*0xFFFF -> MUL gives 0x0001; MULH gives 0xFFFE.
- 100/7 -> DIV gives 14; REM gives 2; div_by_zero=0.
- 5/0 DIV, rd_in=2 -> wb_en one cycle after accept, with wb_data=0xFFFF, div_by_zero=1. The following REM 5/0 gives wb_data=5.
- start pulsed during RUN -> no second result. flush at RUN step 8 -> no wb_en, wb_data keeps its previous value, next start is accepted normally. With MULDIV_SIGNED_EN: -7/2 -> DIV gives 0xFFFD, REM gives 0xFFFF.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one operand bit per clock, single-cycle write-back.
// Optional macro MULDIV_SIGNED_EN: two's complement operands with sign correction at completion.
module muldiv_unit #(
    parameter int WIDTH   = 16,
    parameter int RADDR_W = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic               flush,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    input  logic [RADDR_W-1:0] rd_in,
    output logic               busy,
    output logic               done,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [WIDTH-1:0]   wb_data,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           op_q;
    logic [RADDR_W-1:0]   rd_q;
    logic [WIDTH-1:0]     opb_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     wb_data_q;
    logic                 dbz_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 div_zero_in;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH:0]       rem_shift;
    logic                 rem_take;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     result;

`ifdef MULDIV_SIGNED_EN
    logic neg_q;
    logic rneg_q;

    assign a_mag    = rs_val[WIDTH-1] ? -rs_val : rs_val;
    assign b_mag    = rt_val[WIDTH-1] ? -rt_val : rt_val;
    assign prod_fix = neg_q  ? -prod_q : prod_q;
    assign quo_fix  = neg_q  ? -quo_q  : quo_q;
    assign rem_fix  = rneg_q ? -rem_q  : rem_q;
`else
    assign a_mag    = rs_val;
    assign b_mag    = rt_val;
    assign prod_fix = prod_q;
    assign quo_fix  = quo_q;
    assign rem_fix  = rem_q;
`endif

    assign div_zero_in = op[1] && (rt_val == '0);

    // Right-shifting shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign prod_d  = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring division; the remainder stays below the divisor, so W bits hold it between steps.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_take  = rem_shift >= {1'b0, opb_q};
    assign rem_d     = rem_take ? WIDTH'(rem_shift - {1'b0, opb_q}) : rem_shift[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], rem_take};

    always_comb begin
        result = '0;
        case (op_q)
            2'b00:   result = prod_fix[WIDTH-1:0];
            2'b01:   result = prod_fix[2*WIDTH-1:WIDTH];
            2'b10:   result = quo_fix;
            default: result = rem_fix;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign wb_en       = done && !flush;
    assign wb_rd       = rd_q;
    assign wb_data     = wb_en ? result : wb_data_q;
    assign div_by_zero = dbz_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            opb_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            wb_data_q <= '0;
            dbz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op;
                        rd_q  <= rd_in;
                        cnt_q <= '0;
                        dbz_q <= div_zero_in;
                        if (op[1]) begin
                            opb_q <= b_mag;
                            // Divide by zero skips RUN: preload the defined results directly.
                            quo_q <= div_zero_in ? '1 : a_mag;
                            rem_q <= div_zero_in ? rs_val : '0;
                        end else begin
                            opb_q  <= a_mag;
                            prod_q <= {{WIDTH{1'b0}}, b_mag};
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_q  <= !div_zero_in && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        rneg_q <= !div_zero_in && rs_val[WIDTH-1];
`endif
                        state_q <= div_zero_in ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (op_q[1]) begin
                            rem_q <= rem_d;
                            quo_q <= quo_d;
                        end else begin
                            prod_q <= prod_d;
                        end
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!flush) begin
                        wb_data_q <= result;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
// Honours MULDIV_SIGNED_EN when the same macro is defined for the build.
module tb_muldiv_unit;

    localparam int W  = 16;
    localparam int RW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          flush = 1'b0;
    logic [W-1:0]  rs_val = '0;
    logic [W-1:0]  rt_val = '0;
    logic [RW-1:0] rd_in = '0;
    logic          busy, done, wb_en, div_by_zero;
    logic [RW-1:0] wb_rd;
    logic [W-1:0]  wb_data;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_data = '0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(W), .RADDR_W(RW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .flush(flush),
        .rs_val(rs_val), .rt_val(rt_val), .rd_in(rd_in),
        .busy(busy), .done(done), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p, q, r;
`ifdef MULDIV_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        p = sa * sb;
        case (o)
            2'b00: return p[W-1:0];
            2'b01: return p[2*W-1:W];
            2'b10: begin
                if (b == '0) return '1;
                q = sa / sb;
                return q[W-1:0];
            end
            default: begin
                if (b == '0) return a;
                r = sa % sb;
                return r[W-1:0];
            end
        endcase
    endfunction

    task automatic accept(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [RW-1:0] rd);
        @(negedge CLK);
        start = 1'b1; op = o; rs_val = a; rt_val = b; rd_in = rd;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic count_wb(input int ncyc, output int cnt, output logic [W-1:0] d, output logic [RW-1:0] r);
        cnt = 0; d = '0; r = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge CLK);
            #1;
            if (wb_en) begin
                cnt++; d = wb_data; r = wb_rd;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [RW-1:0] rd);
        logic [W-1:0] e;
        logic         dz;
        int           lat;
        e  = model(o, a, b);
        dz = o[1] && (b == '0);
        accept(o, a, b, rd);
        check("busy_after_accept", busy, 1);
        lat = 0;
        while (!wb_en && lat < 40) begin
            @(posedge CLK);
            #1 lat++;
        end
        check("latency_cycles", lat + 1, dz ? 1 : W + 1);
        check("wb_rd", wb_rd, rd);
        check("wb_data", wb_data, e);
        check("done", done, 1);
        check("div_by_zero", div_by_zero, dz);
        @(posedge CLK);
        #1;
        check("busy_after_done", busy, 0);
        check("wb_en_after_done", wb_en, 0);
        check("wb_data_hold", wb_data, e);
        check("dbz_sticky", div_by_zero, dz);
        $display("op=%0d a=0x%04h b=0x%04h rd=%0d -> data=0x%04h dbz=%0b lat=%0d", o, a, b, rd, wb_data, div_by_zero, lat + 1);
        last_data = e;
    endtask

    initial begin
        int           cnt;
        logic [W-1:0] d;
        logic [RW-1:0] r;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge CLK);
        RST = 1'b0;

        run_op(2'b00, 16'd7, 16'd6, 3'd3);
        check("mul_7x6_const", wb_data, 16'd42);
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 3'd1);
        run_op(2'b01, 16'hFFFF, 16'hFFFF, 3'd4);
        run_op(2'b10, 16'd100, 16'd7, 3'd5);
        run_op(2'b11, 16'd100, 16'd7, 3'd6);
        run_op(2'b10, 16'd5, 16'd0, 3'd2);
        check("div0_const", wb_data, 16'hFFFF);
        run_op(2'b11, 16'd5, 16'd0, 3'd2);
        check("rem0_const", wb_data, 16'd5);
        run_op(2'b10, 16'd9, 16'd3, 3'd7);
`ifdef MULDIV_SIGNED_EN
        run_op(2'b10, 16'hFFF9, 16'd2, 3'd1);
        check("sdiv_const", wb_data, 16'hFFFD);
        run_op(2'b11, 16'hFFF9, 16'd2, 3'd1);
        check("srem_const", wb_data, 16'hFFFF);
        run_op(2'b10, 16'h8000, 16'hFFFF, 3'd2);
        run_op(2'b11, 16'h8000, 16'hFFFF, 3'd2);
        run_op(2'b01, 16'h8000, 16'h8000, 3'd3);
`endif

        // start pulsed during RUN must not produce a second result
        accept(2'b00, 16'd3, 16'd5, 3'd1);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        start = 1'b1; op = 2'b10; rs_val = 16'd50; rt_val = 16'd5; rd_in = 3'd5;
        @(posedge CLK);
        #1 start = 1'b0;
        count_wb(40, cnt, d, r);
        check("start_in_run_pulses", cnt, 1);
        check("start_in_run_data", d, model(2'b00, 16'd3, 16'd5));
        check("start_in_run_rd", r, 1);
        last_data = model(2'b00, 16'd3, 16'd5);
        $display("start-during-run: pulses=%0d data=0x%04h", cnt, d);

        // flush at RUN step 8
        accept(2'b00, 16'h1234, 16'h0056, 3'd4);
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        check("flush_run_busy", busy, 0);
        count_wb(25, cnt, d, r);
        check("flush_run_pulses", cnt, 0);
        check("flush_run_data", wb_data, last_data);
        $display("flush-in-run: pulses=%0d data=0x%04h", cnt, wb_data);
        run_op(2'b11, 16'd1000, 16'd33, 3'd3);

        // flush during DONE suppresses write-back and keeps wb_data
        accept(2'b10, 16'd77, 16'd4, 3'd6);
        repeat (W) @(posedge CLK);
        #1;
        check("flush_done_state", done, 1);
        flush = 1'b1;
        #1;
        check("flush_done_wb_en", wb_en, 0);
        check("flush_done_data", wb_data, last_data);
        @(posedge CLK);
        #1 flush = 1'b0;
        check("flush_done_busy", busy, 0);
        check("flush_done_data_after", wb_data, last_data);
        $display("flush-in-done: data=0x%04h", wb_data);

        // flush and start together in IDLE: nothing accepted
        @(negedge CLK);
        flush = 1'b1; start = 1'b1; op = 2'b00; rs_val = 16'd2; rt_val = 16'd2;
        @(posedge CLK);
        #1 flush = 1'b0; start = 1'b0;
        check("flush_start_idle", busy, 0);

        // asynchronous reset mid-RUN
        accept(2'b01, 16'hABCD, 16'h1357, 3'd7);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wb_en", wb_en, 0);
        check("rst_mid_wb_data", wb_data, 0);
        @(negedge CLK);
        RST = 1'b0;
        count_wb(20, cnt, d, r);
        check("rst_mid_pulses", cnt, 0);
        last_data = '0;
        $display("reset-mid-run: pulses=%0d", cnt);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]    ro;
            logic [W-1:0]  ra, rb;
            logic [RW-1:0] rr;
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rr = RW'($urandom);
            run_op(ro, ra, rb, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
